// File: rtl/pll_lock_supervisor.sv
// Lock supervisor for a Gowin rPLL: pulses the PLL reset, filters the asynchronous LOCK,
// releases N_CH downstream reset domains in staggered order and latches a fault after repeated timeouts.
module pll_lock_supervisor #(
  parameter int N_CH           = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 8,
  parameter int LOCK_TIMEOUT   = 1000,
  parameter int STAGGER        = 4,
  parameter int MAX_RETRY      = 3
) (
  input  logic                           clkin,
  input  logic                           rst_n,
  input  logic                           pll_lock,
  input  logic                           fault_clr,
  output logic                           pll_reset,
  output logic [N_CH-1:0]                ch_rst_n,
  output logic                           ready,
  output logic                           fault,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int RW      = $clog2(MAX_RETRY + 1);
  localparam int TOP_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int TOP_B   = (LOCK_FILTER > N_CH * STAGGER) ? LOCK_FILTER : N_CH * STAGGER;
  localparam int CNT_TOP = (TOP_A > TOP_B) ? TOP_A : TOP_B;
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] FLT_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'((N_CH - 1) * STAGGER);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              lock_meta_q, lock_sync_q;
  logic              boot_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     retry_q, retry_d, retry_inc_s;
  logic [CW:0]       rel_off_s;
  logic              pll_reset_q, pll_reset_d;
  logic [N_CH-1:0]   ch_rst_n_q, ch_rst_n_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;

  // Two-flop synchroniser for the asynchronous LOCK output.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_sync_q <= lock_meta_q;
    end
  end

  // State, shared counter, retry count and registered outputs.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      boot_q      <= 1'b1;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      ch_rst_n_q  <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_q      <= 1'b0;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      ch_rst_n_q  <= ch_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state logic; a lock drop always takes priority over a pending release or timeout.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    retry_inc_s = (retry_q == RETRY_MAX) ? retry_q : retry_q + RW'(1);
    case (state_q)
      S_RESET_PLL: begin
        // The first edge after reset acts as the entry edge, so every PLL reset pulse has equal length.
        if (!boot_q && (cnt_q == RST_LAST)) begin
          state_d = S_WAIT_LOCK;
        end else begin
          state_d = S_RESET_PLL;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_sync_q) begin
          state_d = S_FILTER;
        end else if (cnt_q == TMO_LAST) begin
          retry_d = retry_inc_s;
          state_d = (retry_inc_s == RETRY_MAX) ? S_FAULT : S_RESET_PLL;
        end else begin
          state_d = S_WAIT_LOCK;
        end
      end
      S_FILTER: begin
        if (!lock_sync_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == FLT_LAST) begin
          state_d = S_RELEASE;
        end else begin
          state_d = S_FILTER;
        end
      end
      S_RELEASE: begin
        if (!lock_sync_q) begin
          state_d = S_RESET_PLL;
        end else if (cnt_q == REL_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_RUN: begin
        if (!lock_sync_q) begin
          state_d = S_RESET_PLL;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          state_d = S_RESET_PLL;
          retry_d = '0;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        retry_d = '0;
      end
    endcase
  end

  // Shared saturating counter, cleared whenever the state changes.
  always_comb begin
    cnt_d = cnt_q;
    if (boot_q || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Outputs follow the next state; rel_off_s is the cycle offset from RELEASE entry.
  always_comb begin
    ch_rst_n_d  = '0;
    rel_off_s   = '0;
    pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    ready_d     = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
    if (state_q == S_RELEASE) begin
      rel_off_s = {1'b0, cnt_q} + (CW+1)'(1);
    end else begin
      rel_off_s = '0;
    end
    for (int i = 0; i < N_CH; i++) begin
      ch_rst_n_d[i] = (state_d == S_RUN) ||
                      ((state_d == S_RELEASE) && (rel_off_s >= (CW+1)'(i * STAGGER)));
    end
  end

  assign pll_reset = pll_reset_q;
  assign ch_rst_n  = ch_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: timeline checks from the documented cycle numbers
// plus a phase/elapsed-time reference model compared every cycle under directed and random lock waveforms.
module tb_pll_lock_supervisor;

  localparam int NCH = 3;
  localparam int PRC = 16;
  localparam int LF  = 8;
  localparam int LT  = 1000;
  localparam int STG = 4;
  localparam int MR  = 3;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_FILT = 2;
  localparam int P_REL  = 3;
  localparam int P_RUN  = 4;
  localparam int P_FLT  = 5;

  logic           clkin     = 1'b0;
  logic           rst_n     = 1'b0;
  logic           pll_lock  = 1'b0;
  logic           fault_clr = 1'b0;
  logic           pll_reset;
  logic [NCH-1:0] ch_rst_n;
  logic           ready;
  logic           fault;
  logic [1:0]     retry_cnt;
  logic [7:0]     obs;

  int n_cmp = 0;
  int n_bad = 0;

  int   m_ph    = P_RST;
  int   m_el    = -1;
  int   m_retry = 0;
  logic m_s1    = 1'b0;
  logic m_s2    = 1'b0;

  pll_lock_supervisor #(
    .N_CH(NCH), .PLL_RST_CYCLES(PRC), .LOCK_FILTER(LF),
    .LOCK_TIMEOUT(LT), .STAGGER(STG), .MAX_RETRY(MR)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .fault_clr(fault_clr),
    .pll_reset(pll_reset), .ch_rst_n(ch_rst_n), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt)
  );

  assign obs = {pll_reset, ch_rst_n, ready, fault, retry_cnt};

  always #5 clkin = ~clkin;

  task automatic model_rst();
    m_ph = P_RST; m_el = -1; m_retry = 0; m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  // Reference: phase plus cycles elapsed since entering it; reset release counts as entry.
  task automatic model_step();
    int n;
    int nxt;
    logic ls;
    if (!rst_n) begin
      model_rst();
    end else begin
      ls = m_s2; m_s2 = m_s1; m_s1 = pll_lock;
      n = m_el + 1;
      nxt = m_ph;
      case (m_ph)
        P_RST:  if (n == PRC) nxt = P_WAIT;
        P_WAIT: if (ls) nxt = P_FILT;
                else if (n == LT) begin
                  m_retry = (m_retry < MR) ? m_retry + 1 : MR;
                  nxt = (m_retry == MR) ? P_FLT : P_RST;
                end
        P_FILT: if (!ls) nxt = P_WAIT; else if (n == LF) nxt = P_REL;
        P_REL:  if (!ls) nxt = P_RST;
                else if (n == (NCH - 1) * STG + 1) begin nxt = P_RUN; m_retry = 0; end
        P_RUN:  if (!ls) nxt = P_RST;
        P_FLT:  if (fault_clr) begin nxt = P_RST; m_retry = 0; end
        default: nxt = P_RST;
      endcase
      m_el = (nxt != m_ph) ? 0 : n;
      m_ph = nxt;
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [NCH-1:0] ch;
    logic [1:0] r;
    for (int i = 0; i < NCH; i++) ch[i] = (m_ph == P_RUN) || ((m_ph == P_REL) && (m_el >= i * STG));
    r = 2'(m_retry);
    return {(m_ph == P_RST) || (m_ph == P_FLT), ch, m_ph == P_RUN, m_ph == P_FLT, r};
  endfunction

  task automatic tick();
    @(posedge clkin);
    model_step();
    #1;
  endtask

  // Leaves rst_n released just after an edge, so the next edge is cycle 0.
  task automatic do_reset();
    rst_n = 1'b0; pll_lock = 1'b0; fault_clr = 1'b0;
    model_rst();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_lock = 1'b1; fault_clr = 1'b0;
    model_rst();
    repeat (3) tick();
    n_cmp++;
    if (obs !== 8'b1000_0000) begin
      n_bad++; $display("FAIL reset_values: got %b want %b", obs, 8'b1000_0000);
    end
    n_cmp++;
    if (obs !== model_out()) begin
      n_bad++; $display("FAIL reset_model: got %b want %b", obs, model_out());
    end
  endtask

  task automatic test_nominal(input string tag);
    logic [7:0] want;
    do_reset();
    for (int k = 0; k <= 70; k++) begin
      tick();
      want = {k < 16, k >= 59, k >= 55, k >= 51, k >= 60, 1'b0, 2'b00};
      n_cmp++;
      if (obs !== want) begin
        n_bad++; $display("FAIL %s_timeline cycle %0d: got %b want %b", tag, k, obs, want);
      end
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++; $display("FAIL %s_model cycle %0d: got %b want %b", tag, k, obs, model_out());
      end
      if (k == 40) pll_lock = 1'b1;
    end
  endtask

  task automatic test_glitch();
    int h;
    int rel;
    h = $urandom_range(1, 7);
    rel = 52 + h;
    do_reset();
    for (int k = 0; k <= rel + 12; k++) begin
      tick();
      n_cmp++;
      if ((ch_rst_n[0] !== (k >= rel)) || (retry_cnt !== 2'd0)) begin
        n_bad++; $display("FAIL glitch_release cycle %0d h=%0d: got ch=%b retry=%0d want ch0=%0d retry=0",
                          k, h, ch_rst_n, retry_cnt, (k >= rel));
      end
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++; $display("FAIL glitch_model cycle %0d: got %b want %b", k, obs, model_out());
      end
      if (k == 40) pll_lock = 1'b1;
      if (k == 40 + h) pll_lock = 1'b0;
      if (k == 41 + h) pll_lock = 1'b1;
    end
  endtask

  task automatic test_timeout_fault();
    logic [1:0] wr;
    logic wp;
    logic wf;
    do_reset();
    for (int k = 0; k <= 3125; k++) begin
      tick();
      if (k < 1016) wr = 2'd0;
      else if (k < 2032) wr = 2'd1;
      else if (k < 3048) wr = 2'd2;
      else if (k < 3101) wr = 2'd3;
      else wr = 2'd0;
      wp = (k < 16) || ((k >= 1016) && (k < 1032)) || ((k >= 2032) && (k < 2048)) ||
           ((k >= 3048) && (k < 3117));
      wf = (k >= 3048) && (k < 3101);
      n_cmp++;
      if ({pll_reset, fault, retry_cnt} !== {wp, wf, wr}) begin
        n_bad++; $display("FAIL timeout_timeline cycle %0d: got rst=%b fault=%b retry=%0d want rst=%b fault=%b retry=%0d",
                          k, pll_reset, fault, retry_cnt, wp, wf, wr);
      end
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++; $display("FAIL timeout_model cycle %0d: got %b want %b", k, obs, model_out());
      end
      if (k == 3100) fault_clr = 1'b1;
      if (k == 3101) fault_clr = 1'b0;
    end
  endtask

  task automatic test_lock_loss_run();
    int d;
    int up;
    d = 70 + $urandom_range(0, 20);
    up = d + 3 + $urandom_range(1, 30);
    do_reset();
    for (int k = 0; k <= d + 120; k++) begin
      tick();
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++; $display("FAIL loss_run_model cycle %0d: got %b want %b", k, obs, model_out());
      end
      if (k == d + 2) begin
        n_cmp++;
        if ({ch_rst_n, ready} !== 4'b1111) begin
          n_bad++; $display("FAIL loss_run_before cycle %0d: got ch=%b ready=%b want ch=111 ready=1", k, ch_rst_n, ready);
        end
      end
      if (k == d + 3) begin
        n_cmp++;
        if ({ch_rst_n, ready, pll_reset} !== 5'b00001) begin
          n_bad++; $display("FAIL loss_run_after cycle %0d: got ch=%b ready=%b rst=%b want ch=000 ready=0 rst=1",
                            k, ch_rst_n, ready, pll_reset);
        end
      end
      if (k == d + 120) begin
        n_cmp++;
        if ({ready, retry_cnt} !== 3'b100) begin
          n_bad++; $display("FAIL loss_run_rerun: got ready=%b retry=%0d want ready=1 retry=0", ready, retry_cnt);
        end
      end
      if (k == 40) pll_lock = 1'b1;
      if (k == d) pll_lock = 1'b0;
      if (k == up) pll_lock = 1'b1;
      fault_clr = (k == 64);
    end
    fault_clr = 1'b0;
  endtask

  task automatic test_lock_loss_release();
    do_reset();
    for (int k = 0; k <= 120; k++) begin
      tick();
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++; $display("FAIL loss_rel_model cycle %0d: got %b want %b", k, obs, model_out());
      end
      if ((k >= 51) && (k <= 54)) begin
        n_cmp++;
        if (ch_rst_n !== 3'b001) begin
          n_bad++; $display("FAIL loss_rel_ch0 cycle %0d: got %b want 001", k, ch_rst_n);
        end
      end
      if ((k >= 55) && (k <= 75)) begin
        n_cmp++;
        if (ch_rst_n !== 3'b000) begin
          n_bad++; $display("FAIL loss_rel_cleared cycle %0d: got %b want 000", k, ch_rst_n);
        end
      end
      if (k == 40) pll_lock = 1'b1;
      if (k == 52) pll_lock = 1'b0;
      if (k == 75) pll_lock = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k <= 65; k++) begin
      tick();
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++; $display("FAIL async_pre_model cycle %0d: got %b want %b", k, obs, model_out());
      end
      if (k == 40) pll_lock = 1'b1;
    end
    #3;
    rst_n = 1'b0;
    model_rst();
    #1;
    n_cmp++;
    if (obs !== 8'b1000_0000) begin
      n_bad++; $display("FAIL async_reset_values: got %b want %b", obs, 8'b1000_0000);
    end
    pll_lock = 1'b0;
    test_nominal("after_async");
  endtask

  task automatic test_random();
    int seg;
    seg = 0;
    do_reset();
    for (int k = 0; k < 2500; k++) begin
      tick();
      n_cmp++;
      if (obs !== model_out()) begin
        n_bad++; $display("FAIL random_model cycle %0d: got %b want %b", k, obs, model_out());
      end
      if (seg == 0) begin
        pll_lock = ($urandom_range(0, 3) != 0);
        seg = $urandom_range(1, 60);
      end
      seg--;
      fault_clr = ($urandom_range(0, 31) == 0);
    end
    fault_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal("nominal");
    test_glitch();
    test_timeout_fault();
    test_lock_loss_run();
    test_lock_loss_release();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
